// File: rtl/alu_mul_sequencer.sv
// Shift-add unsigned multiplier controller driving an external ripple ALU.
// Optional MUL_HI_NONZERO_EN adds hi_nz, a flag for a non-zero product high half.
module alu_mul_sequencer #(
  parameter int         WIDTH      = 64,
  parameter logic [3:0] ALU_ADD_OP = 4'b1110,
  parameter int         CNT_W      = 7
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [3:0]         alu_S,
  output logic               alu_cin,
  input  logic [WIDTH-1:0]   alu_f,
  input  logic               alu_cout
`ifdef MUL_HI_NONZERO_EN
  ,
  output logic               hi_nz
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             last;

  // Add only when the current multiplier bit is set.
  always_comb begin
    sum     = q[0] ? {alu_cout, alu_f} : {1'b0, acc};
    acc_nxt = sum[WIDTH:1];
    q_nxt   = {sum[0], q[WIDTH-1:1]};
    last    = (cnt == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (last)  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      acc     <= '0;
      q       <= '0;
      m       <= '0;
      cnt     <= '0;
      product <= '0;
`ifdef MUL_HI_NONZERO_EN
      hi_nz   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (start) begin
            m   <= mcand;
            q   <= mplier;
            acc <= '0;
            cnt <= '0;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          q   <= q_nxt;
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            product <= {acc_nxt, q_nxt};
`ifdef MUL_HI_NONZERO_EN
            hi_nz   <= |acc_nxt;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign alu_a   = acc;
  assign alu_b   = m;
  assign alu_S   = busy ? ALU_ADD_OP : 4'b0000;
  assign alu_cin = 1'b0;

endmodule
